// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between NREQ
// requesters and returns each result on a tagged valid/ready response channel.
module alu_arbiter #(
    parameter int NBIT = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*NBIT-1:0] i_req_a,
    input  logic [NREQ*NBIT-1:0] i_req_b,
    input  logic [NREQ*4-1:0]    i_req_fc,
    output logic [NBIT-1:0]      o_alu_a,
    output logic [NBIT-1:0]      o_alu_b,
    output logic [3:0]           o_alu_fc,
    input  logic [NBIT-1:0]      i_alu_data,
    input  logic                 i_alu_cout,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [NBIT-1:0]      o_rsp_data,
    output logic                 o_rsp_cout,
    output logic                 o_rsp_err,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    state_t state, state_nxt;

    logic [IDW-1:0]    ptr_p0;
    logic [NBIT-1:0]   op_a_p0;
    logic [NBIT-1:0]   op_b_p0;
    logic [3:0]        op_fc_p0;
    logic [IDW-1:0]    op_id_p0;
    logic [NBIT-1:0]   rsp_data_p1;
    logic              rsp_cout_p1;
    logic              rsp_err_p1;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              gnt_found;
    logic [IDW-1:0]    gnt_idx;
    logic [NREQ-1:0]   gnt_oh;
    logic [NBIT-1:0]   sel_a;
    logic [NBIT-1:0]   sel_b;
    logic [3:0]        sel_fc;
    logic              accept;
    logic [NBIT+1:0]   rsp_shaped;

    // Carry is only meaningful for ADD; illegal codes force a zeroed error result.
    function automatic logic [NBIT+1:0] shape_rsp(input logic [3:0]      fc,
                                                  input logic [NBIT-1:0] data,
                                                  input logic            cout);
        logic [NBIT+1:0] r;
        if (fc[3]) begin
            r = {1'b1, 1'b0, {NBIT{1'b0}}};
        end else begin
            r = {1'b0, (fc == 4'd2) ? cout : 1'b0, data};
        end
        return r;
    endfunction

    // Rotate the valid vector so bit 0 is the requester just after the pointer.
    always_comb begin
        req_dbl   = {i_req_valid, i_req_valid};
        req_rot   = NREQ'(req_dbl >> ({1'b0, ptr_p0} + 1'b1));
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr_p0) + 1 + i) % NREQ);
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_fc = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                gnt_oh[k] = gnt_found;
                sel_a     = i_req_a[k*NBIT +: NBIT];
                sel_b     = i_req_b[k*NBIT +: NBIT];
                sel_fc    = i_req_fc[k*4 +: 4];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb rsp_shaped = shape_rsp(op_fc_p0, i_alu_data, i_alu_cout);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            ptr_p0 <= PTR_RST;
        end else begin
            state <= state_nxt;
            if (accept) ptr_p0 <= gnt_idx;
        end
    end

    // p0: operands latched on acceptance
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            op_a_p0  <= '0;
            op_b_p0  <= '0;
            op_fc_p0 <= '0;
            op_id_p0 <= '0;
        end else if (accept) begin
            op_a_p0  <= sel_a;
            op_b_p0  <= sel_b;
            op_fc_p0 <= sel_fc;
            op_id_p0 <= gnt_idx;
        end
    end

    // p1: ALU result captured at the end of EXEC
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rsp_data_p1 <= '0;
            rsp_cout_p1 <= 1'b0;
            rsp_err_p1  <= 1'b0;
        end else if (state == EXEC) begin
            {rsp_err_p1, rsp_cout_p1, rsp_data_p1} <= rsp_shaped;
        end
    end

    assign o_req_ready = (state == IDLE && i_rstn) ? gnt_oh : '0;
    assign o_alu_a     = op_a_p0;
    assign o_alu_b     = op_b_p0;
    assign o_alu_fc    = op_fc_p0;
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_id    = op_id_p0;
    assign o_rsp_data  = rsp_data_p1;
    assign o_rsp_cout  = rsp_cout_p1;
    assign o_rsp_err   = rsp_err_p1;
    assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU model plus a transaction-level
// arbiter model predicting grants, ALU drive and tagged responses every cycle.
module tb_alu_arbiter;
    localparam int NBIT = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ*NBIT-1:0] req_a = '0;
    logic [NREQ*NBIT-1:0] req_b = '0;
    logic [NREQ*4-1:0]    req_fc = '0;
    logic [NBIT-1:0]      o_alu_a, o_alu_b, alu_data;
    logic [3:0]           o_alu_fc;
    logic                 alu_cout;
    logic                 o_rsp_valid, o_rsp_cout, o_rsp_err, o_busy;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       o_rsp_id;
    logic [NBIT-1:0]      o_rsp_data;

    always #5 i_clk = ~i_clk;

    alu_arbiter #(.NBIT(NBIT), .NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_fc(req_fc),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_fc(o_alu_fc),
        .i_alu_data(alu_data), .i_alu_cout(alu_cout),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
        .o_rsp_cout(o_rsp_cout), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
    );

    // External ALU: the adder carry is always produced, whatever the code.
    function automatic logic [NBIT-1:0] alu_fn(input logic [NBIT-1:0] a, b, input logic [3:0] fc);
        case (fc[2:0])
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return a << b[4:0];
            default: return (a < b) ? NBIT'(1) : NBIT'(0);
        endcase
    endfunction

    function automatic logic add_carry(input logic [NBIT-1:0] a, b);
        logic [NBIT:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[NBIT];
    endfunction

    // Expected {err, cout, data} for an operation.
    function automatic logic [NBIT+1:0] exp_rsp(input logic [NBIT-1:0] a, b, input logic [3:0] fc);
        if (fc[3]) return {1'b1, 1'b0, {NBIT{1'b0}}};
        return {1'b0, (fc == 4'd2) ? add_carry(a, b) : 1'b0, alu_fn(a, b, fc)};
    endfunction

    always_comb begin
        alu_data = alu_fn(o_alu_a, o_alu_b, o_alu_fc);
        alu_cout = add_carry(o_alu_a, o_alu_b);
    end

    int nchk = 0;
    int npass = 0;
    int cyc = 0;

    bit             m_idle = 1'b1;
    int             m_age = 0;
    int             m_ptr = NREQ - 1;
    logic [IDW-1:0] m_id;
    logic [NBIT-1:0] m_a, m_b;
    logic [3:0]     m_fc;

    int              last_g;
    bit              last_hs;
    logic [NREQ-1:0] obs_ready;
    logic [3:0]      obs_alu_fc;
    logic [IDW-1:0]  hs_id;
    logic [NBIT-1:0] hs_data;
    logic            hs_cout, hs_err;
    int              rsp_ids[$];
    int              rsp_cycs[$];
    logic [NREQ-1:0] acc_ready;
    logic [3:0]      exec_fc;
    int              op_lat;

    task automatic set_req(input int k, input logic v, input logic [NBIT-1:0] a, b, input logic [3:0] fc);
        req_valid[k]           = v;
        req_a[k*NBIT +: NBIT]  = a;
        req_b[k*NBIT +: NBIT]  = b;
        req_fc[k*4 +: 4]       = fc;
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_age  = 0;
        m_ptr  = NREQ - 1;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        logic [NBIT+1:0] er;
        int g;
        logic exp_v;
        #1;
        g = -1;
        exp_ready = '0;
        if (m_idle) begin
            for (int j = 1; j <= NREQ; j++) begin
                int k;
                k = (m_ptr + j) % NREQ;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready  = o_req_ready;
        obs_alu_fc = o_alu_fc;
        nchk++;
        if (o_req_ready !== exp_ready) $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, o_req_ready, exp_ready);
        else npass++;
        nchk++;
        if (o_busy !== !m_idle) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, !m_idle);
        else npass++;
        exp_v = !m_idle && (m_age >= 2);
        nchk++;
        if (o_rsp_valid !== exp_v) $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, o_rsp_valid, exp_v);
        else npass++;
        if (!m_idle) begin
            nchk++;
            if ({o_alu_a, o_alu_b, o_alu_fc} !== {m_a, m_b, m_fc})
                $display("FAIL alu_drive cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, o_alu_a, o_alu_b, o_alu_fc, m_a, m_b, m_fc);
            else npass++;
        end
        last_hs = 1'b0;
        if (exp_v) begin
            er = exp_rsp(m_a, m_b, m_fc);
            nchk++;
            if ({o_rsp_id, o_rsp_err, o_rsp_cout, o_rsp_data} !== {m_id, er})
                $display("FAIL rsp cyc=%0d got id=%0d err=%b cout=%b data=%h exp id=%0d err=%b cout=%b data=%h",
                         cyc, o_rsp_id, o_rsp_err, o_rsp_cout, o_rsp_data, m_id, er[NBIT+1], er[NBIT], er[NBIT-1:0]);
            else npass++;
            if (rsp_ready) begin
                last_hs = 1'b1;
                hs_id   = o_rsp_id;
                hs_data = o_rsp_data;
                hs_cout = o_rsp_cout;
                hs_err  = o_rsp_err;
                rsp_ids.push_back(int'(o_rsp_id));
                rsp_cycs.push_back(cyc);
            end
        end
        last_g = g;
        @(posedge i_clk);
        cyc++;
        if (g >= 0) begin
            m_idle = 1'b0;
            m_age  = 1;
            m_ptr  = g;
            m_id   = IDW'(g);
            m_a    = req_a[g*NBIT +: NBIT];
            m_b    = req_b[g*NBIT +: NBIT];
            m_fc   = req_fc[g*4 +: 4];
        end else if (!m_idle) begin
            if (m_age >= 2 && rsp_ready) m_idle = 1'b1;
            else m_age++;
        end
        #1;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        rsp_ready = 1'b0;
        i_rstn = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        model_reset();
    endtask

    // Issue one operation from requester k alone and wait for its response.
    task automatic do_op(input int k, input logic [NBIT-1:0] a, b, input logic [3:0] fc);
        bit got;
        req_valid = '0;
        rsp_ready = 1'b1;
        set_req(k, 1'b1, a, b, fc);
        step();
        acc_ready = obs_ready;
        req_valid[k] = 1'b0;
        req_a[k*NBIT +: NBIT] = $urandom;
        got = 1'b0;
        op_lat = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (i == 0) exec_fc = obs_alu_fc;
            got = last_hs;
            op_lat = i + 1;
        end
        nchk++;
        if (!got) $display("FAIL op_timeout req=%0d got=none exp=response", k);
        else npass++;
    endtask

    task automatic test_reset();
        req_valid = '1;
        i_rstn = 1'b0;
        #3;
        nchk++;
        if ({o_req_ready, o_alu_a, o_alu_b, o_alu_fc, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_cout, o_rsp_err, o_busy} !== '0)
            $display("FAIL reset_outputs got ready=%b busy=%b rsp_valid=%b exp=all zero", o_req_ready, o_busy, o_rsp_valid);
        else npass++;
        reset_dut();
        step();
    endtask

    task automatic test_add();
        do_op(2, 32'd5, 32'd7, 4'd2);
        nchk++;
        if (acc_ready !== 4'b0100) $display("FAIL add_ready got=%b exp=0100", acc_ready); else npass++;
        nchk++;
        if (exec_fc !== 4'd2) $display("FAIL add_exec_fc got=%0d exp=2", exec_fc); else npass++;
        nchk++;
        if (op_lat !== 2) $display("FAIL add_latency got=%0d exp=2", op_lat); else npass++;
        nchk++;
        if ({hs_id, hs_data, hs_cout, hs_err} !== {2'd2, 32'd12, 1'b0, 1'b0})
            $display("FAIL add_rsp got id=%0d data=%0d cout=%b err=%b exp id=2 data=12 cout=0 err=0", hs_id, hs_data, hs_cout, hs_err);
        else npass++;
    endtask

    task automatic test_carry();
        do_op(0, 32'hFFFF_FFFF, 32'd1, 4'd2);
        nchk++;
        if ({hs_id, hs_data, hs_cout, hs_err} !== {2'd0, 32'd0, 1'b1, 1'b0})
            $display("FAIL carry_add got data=%h cout=%b err=%b exp data=0 cout=1 err=0", hs_data, hs_cout, hs_err);
        else npass++;
        do_op(0, 32'hFFFF_FFFF, 32'd1, 4'd1);
        nchk++;
        if ({hs_data, hs_cout, hs_err} !== {32'hFFFF_FFFF, 1'b0, 1'b0})
            $display("FAIL carry_or got data=%h cout=%b exp data=ffffffff cout=0", hs_data, hs_cout);
        else npass++;
    endtask

    task automatic test_round_robin();
        int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
        reset_dut();
        rsp_ids.delete();
        rsp_cycs.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 7)));
        for (int c = 0; c < 19; c++) begin
            step();
            if (last_g >= 0) set_req(last_g, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 7)));
        end
        nchk++;
        if (rsp_ids.size() < 6) $display("FAIL rr_count got=%0d exp>=6", rsp_ids.size());
        else npass++;
        for (int i = 0; i < 6 && i < rsp_ids.size(); i++) begin
            nchk++;
            if (rsp_ids[i] !== rr_exp[i]) $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, rsp_ids[i], rr_exp[i]);
            else npass++;
            if (i > 0) begin
                nchk++;
                if (rsp_cycs[i] - rsp_cycs[i-1] !== 3)
                    $display("FAIL rr_spacing idx=%0d got=%0d exp=3", i, rsp_cycs[i] - rsp_cycs[i-1]);
                else npass++;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [IDW-1:0]  s_id;
        logic [NBIT-1:0] s_data;
        bit got;
        reset_dut();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 32'd100, 32'd23, 4'd3);
        set_req(3, 1'b1, 32'd6, 32'd9, 4'd4);
        step();
        nchk++;
        if (obs_ready !== 4'b0010) $display("FAIL bp_first_grant got=%b exp=0010", obs_ready); else npass++;
        req_valid[1] = 1'b0;
        step();
        s_id = o_rsp_id;
        s_data = o_rsp_data;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            nchk++;
            if ({obs_ready, o_rsp_valid, o_rsp_id, o_rsp_data} !== {4'b0000, 1'b1, s_id, s_data})
                $display("FAIL bp_hold i=%0d got ready=%b valid=%b id=%0d data=%0d exp ready=0000 valid=1 id=%0d data=%0d",
                         i, obs_ready, o_rsp_valid, o_rsp_id, o_rsp_data, s_id, s_data);
            else npass++;
        end
        rsp_ready = 1'b1;
        step();
        nchk++;
        if ({last_hs, hs_id, hs_data} !== {1'b1, 2'd1, 32'd77}) $display("FAIL bp_release got hs=%b id=%0d data=%0d exp hs=1 id=1 data=77", last_hs, hs_id, hs_data);
        else npass++;
        step();
        nchk++;
        if (obs_ready !== 4'b1000) $display("FAIL bp_next_grant got=%b exp=1000", obs_ready); else npass++;
        req_valid[3] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin step(); got = last_hs; end
        nchk++;
        if (!got || hs_data !== 32'd15) $display("FAIL bp_second got hs=%b data=%0d exp hs=1 data=15", got, hs_data);
        else npass++;
    endtask

    task automatic test_illegal();
        do_op(1, $urandom, $urandom, 4'b1010);
        nchk++;
        if ({hs_id, hs_data, hs_cout, hs_err} !== {2'd1, 32'd0, 1'b0, 1'b1})
            $display("FAIL illegal_fc got id=%0d data=%h cout=%b err=%b exp id=1 data=0 cout=0 err=1", hs_id, hs_data, hs_cout, hs_err);
        else npass++;
        do_op(1, 32'd3, 32'd9, 4'd7);
        nchk++;
        if ({hs_data, hs_err} !== {32'd1, 1'b0}) $display("FAIL slt got data=%0d err=%b exp data=1 err=0", hs_data, hs_err);
        else npass++;
    endtask

    task automatic test_reset_mid();
        bit got;
        req_valid = '0;
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 32'd40, 32'd2, 4'd2);
        step();
        req_valid[2] = 1'b0;
        set_req(0, 1'b1, 32'd8, 32'd8, 4'd2);
        set_req(3, 1'b1, 32'd1, 32'd1, 4'd2);
        #2;
        i_rstn = 1'b0;
        #1;
        nchk++;
        if ({o_req_ready, o_alu_a, o_alu_b, o_alu_fc, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_cout, o_rsp_err, o_busy} !== '0)
            $display("FAIL midreset_outputs got busy=%b alu_a=%h ready=%b exp=all zero", o_busy, o_alu_a, o_req_ready);
        else npass++;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        model_reset();
        step();
        nchk++;
        if (obs_ready !== 4'b0001) $display("FAIL midreset_priority got=%b exp=0001", obs_ready); else npass++;
        req_valid[0] = 1'b0;
        req_valid[3] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin step(); got = last_hs; end
        nchk++;
        if ({got, hs_id, hs_data} !== {1'b1, 2'd0, 32'd16}) $display("FAIL midreset_rsp got hs=%b id=%0d data=%0d exp hs=1 id=0 data=16", got, hs_id, hs_data);
        else npass++;
    endtask

    task automatic test_random();
        logic [NBIT-1:0] a;
        req_valid = '0;
        last_g = -1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] || last_g == k) begin
                    if ($urandom_range(0, 2) == 0) begin
                        case ($urandom_range(0, 3))
                            0: a = '0;
                            1: a = '1;
                            default: a = $urandom;
                        endcase
                        set_req(k, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
                    end else begin
                        req_valid[k] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance (NBIT-wide, 4-bit function code) between NREQ requesters.
- Accepts one operation at a time with round-robin fairness, drives the ALU from registered operands, and captures the result.
- Returns the result on a single valid/ready response channel tagged with the requester ID.
- Sits between client blocks and the ALU; the ALU's own reset input is tied to i_rstn at the parent level.

Parameters:
- NBIT, 32, operand/result width; must match the ALU instance.
- NREQ, 4, number of requesters; 2..16.
- IDW, 2, requester-ID width; 2^IDW >= NREQ.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_req_valid  input  NREQ  per-requester request valid.
- o_req_ready  output  NREQ  per-requester accept strobe.
- i_req_a  input  NREQ*NBIT  operand A; requester k occupies bits [k*NBIT +: NBIT].
- i_req_b  input  NREQ*NBIT  operand B; same packing as i_req_a.
- i_req_fc  input  NREQ*4  function code; requester k occupies [k*4 +: 4].
- o_alu_a  output  NBIT  to ALU i_data_a.
- o_alu_b  output  NBIT  to ALU i_data_b.
- o_alu_fc  output  4  to ALU i_fc.
- i_alu_data  input  NBIT  from ALU o_data.
- i_alu_cout  input  1  from ALU o_cout.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_id  output  IDW  index of the requester being answered.
- o_rsp_data  output  NBIT  result.
- o_rsp_cout  output  1  carry; only valid for the ADD code (fc=2).
- o_rsp_err  output  1  illegal function code (fc[3]=1).
- o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, i_rstn=0):
  - State goes to IDLE; all outputs clear to 0.
  - Round-robin pointer (last-granted index) resets to NREQ-1, so requester 0 has first priority.
- Reset mid-operation: the in-flight transaction is discarded and no response is issued; requesters must re-request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any i_req_valid bit is set, grant the first valid index searching upward from pointer+1, wrapping modulo NREQ.
  - o_req_ready[grant]=1 combinationally in that cycle only; all other ready bits are 0; ready is never asserted outside IDLE.
  - On that edge: latch the granted A, B, fc and ID into operand registers, set pointer=grant, go to EXEC.
  - No valid bits set: stay in IDLE.
- EXEC:
  - o_alu_a/b/fc are driven from the operand registers; they are stable for the whole of EXEC and RESP and hold their last values in IDLE.
  - One cycle in EXEC: capture i_alu_data and i_alu_cout into the result registers, then go to RESP.
- Response capture rules:
  - o_rsp_cout = i_alu_cout only when fc==4'd2; otherwise 0, because the ALU's carry is stale for other codes.
  - fc[3]=1: o_rsp_data=0, o_rsp_err=1, cout=0; the ALU output is ignored.
- RESP:
  - o_rsp_valid=1; id/data/cout/err are held stable until i_rsp_ready=1.
  - On the handshake edge, go to IDLE and clear o_rsp_valid.
  - A new request is not accepted in the handshake cycle.
- Latency and throughput:
  - Acceptance to o_rsp_valid is 2 cycles.
  - Best-case throughput is 1 operation per 3 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.
- A requester that drops valid before being granted is simply skipped; no state is kept per requester.
- Pointer behaviour: updates only on acceptance.
- Pointer wrap: a pointer of NREQ-1 searches starting from 0.
- Simultaneous valid bits: exactly one grant per IDLE cycle.
- Requester behaviour while waiting:
  - Non-granted requesters hold valid and operands until their own ready pulse.
  - Operands may change freely after acceptance.
- o_busy = (state != IDLE).

Test Plan:
- Reset, then requester 2 only: a=5, b=7, fc=2 -> o_req_ready=4'b0100 in one cycle, o_alu_fc=2 next cycle, o_rsp_valid two cycles after acceptance with id=2, data=12, cout=0, err=0.
- Requester 0: a=32'hFFFF_FFFF, b=1, fc=2 -> data=0, cout=1. Then fc=1 with the same operands -> cout=0 even though the ALU's o_cout is still 1.
- All four valid continuously, i_rsp_ready=1 -> response ids 0,1,2,3,0,1 in order, one response every 3 cycles.
- i_rsp_ready held 0 for 5 cycles during RESP -> o_rsp_valid, id and data stay constant, o_req_ready stays 0; ready=1 -> IDLE, next grant issued in the following cycle.
- Requester 1 with fc=4'b1010 -> data=0, err=1, cout=0. Then fc=7, a=3, b=9 -> data=1, err=0.
- Assert i_rstn=0 during EXEC -> all outputs 0 immediately; after release, o_rsp_valid never rises for the aborted op, and requester 0 gets priority on the next grant.
